sram_port_arbiter: RTL and testbench

Shares the single external SRAM port (SRAM_ADDR/SRAM_DATA/SRAM_WE_n) between three requesters: the CGA/Tandy video fetch, the ioctl BIOS/ROM download, and the CPU/DMA memory cycle.
- Sits between the peripheral memory decode and the SRAM pins.
- Sequences each access through setup, strobe and turnaround phases.
- Returns per-requester acknowledge; the CPU acknowledge feeds the chipset READY logic.

---
 rtl/sram_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - three-way arbiter and access sequencer for the shared SRAM port
module sram_port_arbiter #(
  parameter int ADDR_WIDTH    = 19,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  vid_req,
  input  logic [ADDR_WIDTH-1:0] vid_addr,
  output logic                  vid_ack,
  output logic [7:0]            vid_rdata,
  input  logic                  dl_req,
  input  logic [ADDR_WIDTH-1:0] dl_addr,
  input  logic [7:0]            dl_wdata,
  output logic                  dl_ack,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [7:0]            cpu_wdata,
  output logic                  cpu_ack,
  output logic [7:0]            cpu_rdata,
  output logic                  cpu_wait,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  inout  wire  [7:0]            sram_data,
  output logic                  sram_we_n,
  output logic                  sram_oe_n
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_ACK
  } state_t;

  typedef enum logic [1:0] {
    OWN_VID,
    OWN_DL,
    OWN_CPU
  } owner_t;

  // Counter terminal value; ACCESS lasts cnt 0..LAST_CNT.
  localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

  state_t                  state_q, state_d;
  owner_t                  owner_q, owner_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]              wdata_q, wdata_d;
  logic                    we_q, we_d;
  logic                    cpu_boost_q, cpu_boost_d;
  logic [7:0]              vid_rdata_q, vid_rdata_d;
  logic [7:0]              cpu_rdata_q, cpu_rdata_d;
  logic                    in_strobe;
  logic                    drive_bus;

  // State and latch registers; reset aborts any access in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_VID;
      cnt_q       <= 4'd0;
      addr_q      <= '0;
      wdata_q     <= 8'h00;
      we_q        <= 1'b0;
      cpu_boost_q <= 1'b0;
      vid_rdata_q <= 8'h00;
      cpu_rdata_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      cpu_boost_q <= cpu_boost_d;
      vid_rdata_q <= vid_rdata_d;
      cpu_rdata_q <= cpu_rdata_d;
    end
  end

  // Arbitration in IDLE, then SETUP -> ACCESS (counted) -> ACK -> IDLE.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    cpu_boost_d = cpu_boost_q;
    vid_rdata_d = vid_rdata_q;
    cpu_rdata_d = cpu_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (vid_req || dl_req || cpu_req) begin
          state_d = ST_SETUP;
          if (vid_req) begin
            owner_d = OWN_VID;
            addr_d  = vid_addr;
            we_d    = 1'b0;
          end else if (cpu_req && cpu_boost_q) begin
            owner_d = OWN_CPU;
            addr_d  = cpu_addr;
            we_d    = cpu_we;
            wdata_d = cpu_wdata;
          end else if (dl_req) begin
            owner_d = OWN_DL;
            addr_d  = dl_addr;
            we_d    = 1'b1;
            wdata_d = dl_wdata;
          end else begin
            owner_d = OWN_CPU;
            addr_d  = cpu_addr;
            we_d    = cpu_we;
            wdata_d = cpu_wdata;
          end
          // A CPU passed over once jumps ahead of the download next time.
          if (owner_d == OWN_CPU) begin
            cpu_boost_d = 1'b0;
          end else if (cpu_req) begin
            cpu_boost_d = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
        cnt_d   = 4'd0;
      end
      ST_ACCESS: begin
        if (cnt_q == LAST_CNT) begin
          state_d = ST_ACK;
          if (!we_q) begin
            if (owner_q == OWN_VID) begin
              vid_rdata_d = sram_data;
            end else if (owner_q == OWN_CPU) begin
              cpu_rdata_d = sram_data;
            end
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pin strobes decode straight from the state register so reset releases them at once.
  assign in_strobe = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign drive_bus = in_strobe && we_q;
  assign sram_addr = addr_q;
  assign sram_data = drive_bus ? wdata_q : 8'bzzzzzzzz;
  assign sram_oe_n = ~(in_strobe && !we_q);
  assign sram_we_n = ~((state_q == ST_ACCESS) && we_q);

  assign vid_ack   = (state_q == ST_ACK) && (owner_q == OWN_VID);
  assign dl_ack    = (state_q == ST_ACK) && (owner_q == OWN_DL);
  assign cpu_ack   = (state_q == ST_ACK) && (owner_q == OWN_CPU);
  assign cpu_wait  = cpu_req & ~cpu_ack;
  assign vid_rdata = vid_rdata_q;
  assign cpu_rdata = cpu_rdata_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - randomized self-checking bench for sram_port_arbiter
module tb_sram_port_arbiter;
  localparam int AW   = 19;
  localparam int AC   = 2;
  localparam int SLOT = AC + 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          vid_req, dl_req, cpu_req, cpu_we;
  logic [AW-1:0] vid_addr, dl_addr, cpu_addr;
  logic [7:0]    dl_wdata, cpu_wdata;
  logic          vid_ack, dl_ack, cpu_ack, cpu_wait, sram_we_n, sram_oe_n;
  logic [7:0]    vid_rdata, cpu_rdata;
  logic [AW-1:0] sram_addr;
  wire  [7:0]    sram_data;

  bit [7:0] dev_mem [0:(1<<AW)-1];
  bit [7:0] ref_mem [0:(1<<AW)-1];

  int n_checks = 0;
  int n_fail   = 0;

  // Requester control from the main sequence
  int            vid_go_cnt = 0, dl_go_cnt = 0, cpu_go_cnt = 0;
  logic [AW-1:0] vid_go_addr = '0, dl_go_addr = '0, cpu_go_addr = '0;
  logic [7:0]    dl_go_data = 8'h00, cpu_go_data = 8'h00;
  logic          cpu_go_we = 1'b0;
  logic          vid_rnd = 1'b0, dl_rnd = 1'b0, cpu_rnd = 1'b0, vid_hog = 1'b0;

  // Reference model state
  int            m_ph = 0;
  int            m_owner = 0;
  logic [AW-1:0] m_addr = '0;
  logic          m_we = 1'b0;
  logic [7:0]    m_wd = 8'h00;
  logic          m_boost = 1'b0;
  logic [7:0]    m_vid_rd = 8'h00, m_cpu_rd = 8'h00;

  sram_port_arbiter #(.ADDR_WIDTH(AW), .ACCESS_CYCLES(AC)) dut (
    .clock(clock), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
    .dl_req(dl_req), .dl_addr(dl_addr), .dl_wdata(dl_wdata), .dl_ack(dl_ack),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_wait(cpu_wait),
    .sram_addr(sram_addr), .sram_data(sram_data), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
  );

  always #5 clock = ~clock;

  // SRAM device: drives read data while output-enabled
  assign sram_data = (!sram_oe_n && sram_we_n) ? dev_mem[sram_addr] : 8'bzzzzzzzz;
  wire bus_released = (sram_data === 8'bzzzzzzzz) || (sram_data == 8'h00);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    a = AW'($urandom_range(0, 15));
    if ($urandom_range(0, 1) == 1) a[AW-1:AW-3] = 3'b111;
    return a;
  endfunction

  // SRAM device write capture
  initial begin : sram_dev
    for (int i = 0; i < 32; i++) dev_mem[i] = 8'(i * 37 + 11);
    dev_mem[19'h12345] = 8'hA5;
    forever begin
      @(negedge clock);
      if (!reset && !sram_we_n) dev_mem[sram_addr] = sram_data;
    end
  end

  // Behavioural model: elapsed cycles since grant define the phase
  task automatic model_step();
    int win;
    if (reset) begin
      m_ph = 0; m_owner = 0; m_boost = 1'b0; m_addr = '0; m_we = 1'b0;
      m_vid_rd = 8'h00; m_cpu_rd = 8'h00;
      return;
    end
    if (m_ph == 0) begin
      if (vid_req) win = 1;
      else if (cpu_req && m_boost) win = 3;
      else if (dl_req) win = 2;
      else if (cpu_req) win = 3;
      else win = 0;
      if (win != 0) begin
        if (win == 3) m_boost = 1'b0;
        else if (cpu_req) m_boost = 1'b1;
        m_owner = win;
        m_ph = 1;
        if (win == 1) begin m_addr = vid_addr; m_we = 1'b0; end
        else if (win == 2) begin m_addr = dl_addr; m_we = 1'b1; m_wd = dl_wdata; end
        else begin m_addr = cpu_addr; m_we = cpu_we; m_wd = cpu_wdata; end
      end
    end else if (m_ph == AC + 1) begin
      if (m_we) ref_mem[m_addr] = m_wd;
      else if (m_owner == 1) m_vid_rd = ref_mem[m_addr];
      else m_cpu_rd = ref_mem[m_addr];
      m_ph = AC + 2;
    end else if (m_ph == AC + 2) begin
      m_ph = 0;
    end else begin
      m_ph = m_ph + 1;
    end
  endtask

  initial begin : model_proc
    for (int i = 0; i < 32; i++) ref_mem[i] = 8'(i * 37 + 11);
    ref_mem[19'h12345] = 8'hA5;
    forever begin
      @(posedge clock or posedge reset);
      model_step();
    end
  end

  // Per-cycle comparison against the model
  initial begin : compare_proc
    bit e_str, e_acc, e_ack;
    forever begin
      @(negedge clock);
      e_str = (m_ph >= 1) && (m_ph <= AC + 1);
      e_acc = (m_ph >= 2) && (m_ph <= AC + 1);
      e_ack = (m_ph == AC + 2);
      check("vid_ack", 32'(vid_ack), 32'(e_ack && m_owner == 1));
      check("dl_ack", 32'(dl_ack), 32'(e_ack && m_owner == 2));
      check("cpu_ack", 32'(cpu_ack), 32'(e_ack && m_owner == 3));
      check("cpu_wait", 32'(cpu_wait), 32'(cpu_req && !(e_ack && m_owner == 3)));
      check("sram_addr", 32'(sram_addr), 32'(m_addr));
      check("sram_oe_n", 32'(sram_oe_n), 32'(!(e_str && !m_we)));
      check("sram_we_n", 32'(sram_we_n), 32'(!(e_acc && m_we)));
      check("vid_rdata", 32'(vid_rdata), 32'(m_vid_rd));
      check("cpu_rdata", 32'(cpu_rdata), 32'(m_cpu_rd));
      if (e_str && m_we) check("sram_data_drive", 32'(sram_data), 32'(m_wd));
      else if (!e_str) check("sram_data_release", 32'(bus_released), 32'd1);
    end
  end

  // Requester agents: hold until ack, drop on the edge after ack
  initial begin : vid_agent
    bit got;
    int done;
    done = 0;
    vid_req = 1'b0; vid_addr = '0;
    forever begin
      @(negedge clock); got = vid_ack;
      @(posedge clock); #1;
      if (vid_req) begin
        if (got) begin
          if (vid_hog) vid_addr = rand_addr();
          else vid_req = 1'b0;
        end
      end else if (done != vid_go_cnt) begin
        done++; vid_req = 1'b1; vid_addr = vid_go_addr;
      end else if (vid_rnd && $urandom_range(0, 2) == 0) begin
        vid_req = 1'b1; vid_addr = rand_addr();
      end
    end
  end

  initial begin : dl_agent
    bit got;
    int done;
    done = 0;
    dl_req = 1'b0; dl_addr = '0; dl_wdata = 8'h00;
    forever begin
      @(negedge clock); got = dl_ack;
      @(posedge clock); #1;
      if (dl_req) begin
        if (got) dl_req = 1'b0;
      end else if (done != dl_go_cnt) begin
        done++; dl_req = 1'b1; dl_addr = dl_go_addr; dl_wdata = dl_go_data;
      end else if (dl_rnd && $urandom_range(0, 2) == 0) begin
        dl_req = 1'b1; dl_addr = rand_addr(); dl_wdata = 8'($urandom);
      end
    end
  end

  initial begin : cpu_agent
    bit got;
    int done;
    done = 0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = 8'h00;
    forever begin
      @(negedge clock); got = cpu_ack;
      @(posedge clock); #1;
      if (cpu_req) begin
        if (got) cpu_req = 1'b0;
      end else if (done != cpu_go_cnt) begin
        done++; cpu_req = 1'b1; cpu_we = cpu_go_we; cpu_addr = cpu_go_addr; cpu_wdata = cpu_go_data;
      end else if (cpu_rnd && $urandom_range(0, 2) == 0) begin
        cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1)); cpu_addr = rand_addr(); cpu_wdata = 8'($urandom);
      end
    end
  end

  // Directed sequence followed by randomized traffic
  initial begin : main_seq
    int n, c1, c2, c3, v_n, d_n, c_n, v_c, d_c, c_c;
    bit ok, flag;

    repeat (2) @(negedge clock);
    check("rst_vid_ack", 32'(vid_ack), 32'd0);
    check("rst_dl_ack", 32'(dl_ack), 32'd0);
    check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    check("rst_we_n", 32'(sram_we_n), 32'd1);
    check("rst_oe_n", 32'(sram_oe_n), 32'd1);
    check("rst_addr", 32'(sram_addr), 32'd0);
    check("rst_bus", 32'(bus_released), 32'd1);
    check("rst_rdata", 32'({vid_rdata, cpu_rdata}), 32'd0);
    #2 reset = 1'b0;
    repeat (3) @(negedge clock);

    // Single CPU read
    cpu_go_addr = 19'h12345; cpu_go_we = 1'b0; cpu_go_cnt++;
    ok = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clock); if (cpu_req) begin ok = 1; break; end end
    check("t1_req_seen", 32'(ok), 32'd1);
    n = 0; c1 = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (!sram_oe_n) c1++;
      if (cpu_ack) begin n = i; break; end
    end
    check("t1_ack_latency", 32'(n), 32'(AC + 2));
    check("t1_oe_low_cycles", 32'(c1), 32'(AC + 1));
    check("t1_cpu_rdata", 32'(cpu_rdata), 32'h0A5);
    @(negedge clock);
    check("t1_cpu_wait_after", 32'(cpu_wait), 32'd0);
    check("t1_ack_single", 32'(cpu_ack), 32'd0);
    repeat (3) @(negedge clock);

    // Download write at the top address
    dl_go_addr = 19'h7FFFF; dl_go_data = 8'h3C; dl_go_cnt++;
    ok = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clock); if (dl_req) begin ok = 1; break; end end
    check("t2_req_seen", 32'(ok), 32'd1);
    n = 0; c1 = 0; c2 = 0; c3 = 0; flag = 0;
    for (int i = 1; i <= AC + 6; i++) begin
      @(negedge clock);
      if (!sram_we_n) c1++;
      if (i <= AC + 1 && sram_data == 8'h3C) c2++;
      if (dl_ack) begin c3++; n = i; flag = bus_released; end
    end
    check("t2_ack_latency", 32'(n), 32'(AC + 2));
    check("t2_we_low_cycles", 32'(c1), 32'(AC));
    check("t2_data_driven", 32'(c2), 32'(AC + 1));
    check("t2_ack_count", 32'(c3), 32'd1);
    check("t2_bus_z_in_ack", 32'(flag), 32'd1);
    check("t2_mem_written", 32'(dev_mem[19'h7FFFF]), 32'h03C);

    // Simultaneous requests: vid, boosted cpu, then dl
    vid_go_addr = 19'd5; dl_go_addr = 19'd6; dl_go_data = 8'h77;
    cpu_go_addr = 19'd7; cpu_go_we = 1'b0;
    vid_go_cnt++; dl_go_cnt++; cpu_go_cnt++;
    ok = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clock); if (vid_req) begin ok = dl_req && cpu_req; break; end end
    check("t3_reqs_together", 32'(ok), 32'd1);
    v_n = 0; d_n = 0; c_n = 0; v_c = 0; d_c = 0; c_c = 0;
    for (int i = 1; i <= 3 * SLOT + 5; i++) begin
      @(negedge clock);
      if (vid_ack) begin v_c++; if (v_n == 0) v_n = i; end
      if (dl_ack) begin d_c++; if (d_n == 0) d_n = i; end
      if (cpu_ack) begin c_c++; if (c_n == 0) c_n = i; end
    end
    check("t3_vid_slot", 32'(v_n), 32'(AC + 2));
    check("t3_cpu_slot", 32'(c_n), 32'(AC + 2 + SLOT));
    check("t3_dl_slot", 32'(d_n), 32'(AC + 2 + 2 * SLOT));
    check("t3_ack_counts", 32'({v_c[7:0], d_c[7:0], c_c[7:0]}), 32'h010101);

    // Continuous video starves the CPU until video idles
    vid_hog = 1'b1; vid_go_addr = 19'd9; vid_go_cnt++;
    cpu_go_addr = 19'd10; cpu_go_we = 1'b1; cpu_go_data = 8'h42; cpu_go_cnt++;
    ok = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clock); if (cpu_req) begin ok = 1; break; end end
    check("t4_req_seen", 32'(ok), 32'd1);
    flag = 1; v_c = 0; c_c = 0;
    repeat (8 * SLOT) begin
      @(negedge clock);
      if (!cpu_wait) flag = 0;
      if (vid_ack) v_c++;
      if (cpu_ack) c_c++;
    end
    check("t4_cpu_wait_high", 32'(flag), 32'd1);
    check("t4_cpu_no_ack", 32'(c_c), 32'd0);
    check("t4_vid_progress", 32'(v_c >= 7), 32'd1);
    vid_hog = 1'b0;
    ok = 0;
    for (int i = 0; i < 4 * SLOT; i++) begin @(negedge clock); if (cpu_ack) begin ok = 1; break; end end
    check("t4_cpu_done", 32'(ok), 32'd1);
    repeat (10) @(negedge clock);

    // Reset during the ACCESS phase of a write
    dl_go_addr = 19'h155; dl_go_data = 8'h99; dl_go_cnt++;
    ok = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clock); if (!sram_we_n) begin ok = 1; break; end end
    check("t5_write_started", 32'(ok), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("t5_abort_we_n", 32'(sram_we_n), 32'd1);
    check("t5_abort_oe_n", 32'(sram_oe_n), 32'd1);
    check("t5_abort_bus", 32'(bus_released), 32'd1);
    check("t5_abort_addr", 32'(sram_addr), 32'd0);
    c1 = 0;
    repeat (2) begin @(negedge clock); if (dl_ack) c1++; end
    #2 reset = 1'b0;
    check("t5_no_ack_in_reset", 32'(c1), 32'd0);
    n = 0;
    for (int i = 1; i <= 20; i++) begin @(negedge clock); if (dl_ack) begin n = i; break; end end
    check("t5_reissue_latency", 32'(n), 32'(AC + 2));
    check("t5_mem_written", 32'(dev_mem[19'h155]), 32'h099);
    repeat (5) @(negedge clock);

    // Randomized traffic from all three requesters
    vid_rnd = 1'b1; dl_rnd = 1'b1; cpu_rnd = 1'b1;
    repeat (3000) @(negedge clock);
    vid_rnd = 1'b0; dl_rnd = 1'b0; cpu_rnd = 1'b0;
    repeat (60) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
